sort4_seq_ctrl: RTL and testbench
=================================

Name: sort4_seq_ctrl

Overview:
- Sequential sorting controller that time-shares one external 4-bit magnitude comparator (gt/eq/lt outputs) to sort a small burst of values into ascending order.
- Accepts N values serially through a valid/ready input port, then runs a fixed-length bubble sort, driving the comparator operands and swapping on "greater than".
- Streams the sorted values out through a valid/ready output port.
- Sits between a producer (switch/testbench stimulus) and a consumer (display/checker), with the comparator instantiated alongside it at the top level.

Parameters:
- N, 4, number of elements per burst; legal range 2..16.
- W, 4, element width; fixed at 4 to match the comparator; other values are illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a value on in_data.
- in_data  input  W  value to load.
- in_ready  output  1  controller can accept a value.
- out_valid  output  1  out_data holds a sorted value.
- out_data  output  W  sorted value, smallest first.
- out_ready  input  1  consumer accepts out_data.
- cmp_a  output  W  comparator operand A = mem[j].
- cmp_b  output  W  comparator operand B = mem[j+1].
- cmp_gt  input  1  comparator A_gt_B.
- cmp_eq  input  1  comparator A_eq_B.
- cmp_lt  input  1  comparator A_lt_B.
- busy  output  1  high in SORT and DRAIN.
- sort_done  output  1  one-cycle pulse on the SORT→DRAIN transition.
- cmp_err  output  1  sticky flag: comparator one-hot violation seen during SORT.

Behaviour:
- Storage: mem[0..N-1] of W bits.
- Counters: load/drain index k (0..N-1); pass index i and compare index j, both 0..N-2.
- All registers update on the rising edge of clk only.
- Reset:
  - rst=1 forces state LOAD and clears mem, k, i, j, sort_done and cmp_err to 0.
  - After reset: in_ready=1, out_valid=0, out_data=0, busy=0, cmp_a=cmp_b=0.
  - rst has priority over every other event.
  - Reset in any state, including mid-SORT or mid-DRAIN, discards partial data with no output.
- State LOAD:
  - in_ready=1, out_valid=0, busy=0.
  - On in_valid&&in_ready: mem[k]<=in_data, k<=k+1.
  - On the handshake where k==N-1: k<=0, i<=0, j<=0, next state SORT.
- State SORT:
  - in_ready=0, out_valid=0.
  - cmp_a/cmp_b are combinational from mem[j]/mem[j+1].
  - Comparator result is sampled in the same cycle.
  - cmp_gt=1: swap mem[j] and mem[j+1] at the clock edge.
  - cmp_eq or cmp_lt: no swap, so equal values keep their order (stable).
  - Each cycle: j<=j+1.
  - When j==N-2-i: j<=0, i<=i+1.
  - When i==N-2 and j==0 (last compare): go to DRAIN and pulse sort_done for one cycle.
  - Passes shrink, so SORT lasts exactly N(N-1)/2 cycles (6 for N=4).
  - No early exit; latency is fixed.
- cmp_err:
  - Set when, in any SORT cycle, cmp_gt+cmp_eq+cmp_lt != 1.
  - Stays set until rst.
  - The sort proceeds regardless, using cmp_gt only.
- State DRAIN:
  - out_valid=1 and out_data=mem[k]; in_ready=0.
  - On out_ready: k<=k+1.
  - On the handshake where k==N-1: k<=0, next state LOAD.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- Timing:
  - Last load handshake at edge t.
  - SORT occupies cycles t..t+N(N-1)/2-1.
  - out_valid first rises in the cycle after the sort_done pulse.
  - After the last drain handshake, in_ready=1 in the next cycle.
  - No cycle has both in_ready and out_valid high.
- In non-LOAD/DRAIN states, in_valid and out_ready are ignored; values are not lost because in_ready=0.
- cmp_a and cmp_b show mem[j]/mem[j+1] in every state.
- Ports outside SORT carry no handshake meaning.

Test Plan:
- Reset then load 9,3,7,3 (in_valid held high) → sort_done pulses 6 cycles after the last load; drain order 3,3,7,9; cmp_err=0.
- Load 15,10,5,0 (reverse order, 6 swaps) → output 0,5,10,15; cycle count to first out_valid identical to the previous scenario.
- Load 1,2,3,4, then 8,8,8,8 back-to-back → outputs 1,2,3,4 then 8,8,8,8; no swaps; in_ready returns 1 the cycle after the 4th drain.
- Drain with out_ready toggling 1,0,0,1,… → out_data held stable during stalls; all 4 values delivered once in order; in_valid pulses during DRAIN are ignored.
- Assert rst for 1 cycle during SORT (cycle 3), then load 6,2,4,1 → no output from the aborted burst; new output 1,2,4,6.
- Force cmp_gt=cmp_lt=1 during one SORT cycle → cmp_err=1 and held through the following bursts until rst clears it.

Source files
------------

// File: rtl/sort4_seq_ctrl.sv
// Sequential bubble-sort controller: loads N values, sorts them using an external
// magnitude comparator, then streams them out smallest first.
module sort4_seq_ctrl #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  input  logic         cmp_gt,
  input  logic         cmp_eq,
  input  logic         cmp_lt,
  output logic         busy,
  output logic         sort_done,
  output logic         cmp_err
);

  localparam int unsigned IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);
  localparam logic [IW-1:0] LastCmp = IW'(N - 2);

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  mem_d [N];
  logic [IW-1:0] k_q, k_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic          cmp_err_q, cmp_err_d;
  logic [IW-1:0] j_nxt;
  logic [1:0]    cmp_sum;

  assign j_nxt   = j_q + 1'b1;
  assign cmp_sum = {1'b0, cmp_gt} + {1'b0, cmp_eq} + {1'b0, cmp_lt};
  assign cmp_a   = mem_q[j_q];
  assign cmp_b   = mem_q[j_nxt];
  assign cmp_err = cmp_err_q;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    k_d       = k_q;
    i_d       = i_q;
    j_d       = j_q;
    cmp_err_d = cmp_err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    sort_done = 1'b0;

    case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_d[k_q] = in_data;
          if (k_q == LastIdx) begin
            k_d     = '0;
            i_d     = '0;
            j_d     = '0;
            state_d = StSort;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      StSort: begin
        busy = 1'b1;
        // Only gt drives the swap, so equal elements keep their order.
        if (cmp_gt) begin
          mem_d[j_q]   = mem_q[j_nxt];
          mem_d[j_nxt] = mem_q[j_q];
        end
        if (cmp_sum != 2'd1) begin
          cmp_err_d = 1'b1;
        end
        if (i_q == LastCmp && j_q == '0) begin
          sort_done = 1'b1;
          i_d       = '0;
          j_d       = '0;
          state_d   = StDrain;
        end else if (j_q == LastCmp - i_q) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_nxt;
        end
      end

      StDrain: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem_q[k_q];
        if (out_ready) begin
          if (k_q == LastIdx) begin
            k_d     = '0;
            state_d = StLoad;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      mem_q     <= '{default: '0};
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      cmp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      k_q       <= k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      cmp_err_q <= cmp_err_d;
    end
  end

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Scoreboard bench for sort4_seq_ctrl with a behavioural comparator that can be
// forced into a non-one-hot result.
module tb_sort4_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic [3:0] cmp_a, cmp_b;
  logic       cmp_gt, cmp_eq, cmp_lt;
  logic       busy, sort_done, cmp_err;
  logic       force_bad = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  assign cmp_gt = force_bad ? 1'b1 : (cmp_a > cmp_b);
  assign cmp_eq = force_bad ? 1'b0 : (cmp_a == cmp_b);
  assign cmp_lt = force_bad ? 1'b1 : (cmp_a < cmp_b);

  sort4_seq_ctrl #(.N(4), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_gt    (cmp_gt),
    .cmp_eq    (cmp_eq),
    .cmp_lt    (cmp_lt),
    .busy      (busy),
    .sort_done (sort_done),
    .cmp_err   (cmp_err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  logic       held_valid = 1'b0;
  logic [3:0] held_data  = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (in_ready && out_valid) check("in_ready_and_out_valid", 1, 0);
      if (held_valid && out_valid) check("stall_stable", int'(out_data), int'(held_data));
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'(out_data), -1);
        end else begin
          check("out_data", int'(out_data), int'(exp_q.pop_front()));
        end
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  task automatic push4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d);
    logic [3:0] v[4];
    v = '{a, b, c, d};
    for (int n = 0; n < 4; n++) begin
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = v[n];
      @(negedge clk);
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) check("load_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Entered one step after the last load edge; observes the SORT phase.
  task automatic run_sort(input logic [3:0] exp_a, input logic [3:0] exp_b,
                          input int bad_cyc, input logic exp_err);
    int cnt, sd_at, sd_pulses, ov_at;
    cnt = 0; sd_at = 0; sd_pulses = 0; ov_at = 0;
    while (ov_at == 0 && cnt < 40) begin
      force_bad = (cnt + 1 == bad_cyc);
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        check("sort_busy", int'(busy), 1);
        check("sort_in_ready", int'(in_ready), 0);
        check("sort_cmp_a", int'(cmp_a), int'(exp_a));
        check("sort_cmp_b", int'(cmp_b), int'(exp_b));
      end
      if (sort_done) begin
        sd_pulses++;
        if (sd_at == 0) sd_at = cnt;
      end
      if (out_valid) ov_at = cnt;
      @(posedge clk);
      #1;
    end
    force_bad = 1'b0;
    check("sort_done_cycle", sd_at, 6);
    check("sort_done_pulses", sd_pulses, 1);
    check("first_out_valid_cycle", ov_at, 7);
    check("cmp_err_after_sort", int'(cmp_err), int'(exp_err));
  endtask

  task automatic drain4(input logic [7:0] pat, input bit poke_in);
    int hs, cyc;
    hs = 0; cyc = 0;
    while (hs < 4 && cyc < 100) begin
      out_ready = pat[cyc % 8];
      in_valid  = poke_in & cyc[0];
      in_data   = 4'hf;
      @(negedge clk);
      if (out_valid && out_ready) hs++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 100) check("drain_timeout", 0, 1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("post_drain_in_ready", int'(in_ready), 1);
    check("post_drain_out_valid", int'(out_valid), 0);
    check("post_drain_busy", int'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cmp_a", int'(cmp_a), 0);
    check("rst_cmp_b", int'(cmp_b), 0);
    check("rst_sort_done", int'(sort_done), 0);
    check("rst_cmp_err", int'(cmp_err), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    do_reset();

    // Duplicates keep their order
    push4(4'd3, 4'd3, 4'd7, 4'd9);
    load4(4'd9, 4'd3, 4'd7, 4'd3);
    run_sort(4'd9, 4'd3, 0, 1'b0);
    drain4(8'hff, 1'b0);

    // Reverse order, every compare swaps
    push4(4'd0, 4'd5, 4'd10, 4'd15);
    load4(4'd15, 4'd10, 4'd5, 4'd0);
    run_sort(4'd15, 4'd10, 0, 1'b0);
    drain4(8'hff, 1'b0);

    // Already sorted, then all equal, back-to-back
    push4(4'd1, 4'd2, 4'd3, 4'd4);
    load4(4'd1, 4'd2, 4'd3, 4'd4);
    run_sort(4'd1, 4'd2, 0, 1'b0);
    drain4(8'hff, 1'b0);
    push4(4'd8, 4'd8, 4'd8, 4'd8);
    load4(4'd8, 4'd8, 4'd8, 4'd8);
    run_sort(4'd8, 4'd8, 0, 1'b0);
    drain4(8'hff, 1'b0);

    // Stalled drain with in_valid pokes
    push4(4'd1, 4'd2, 4'd6, 4'd12);
    load4(4'd12, 4'd1, 4'd6, 4'd2);
    run_sort(4'd12, 4'd1, 0, 1'b0);
    drain4(8'b1001_1001, 1'b1);

    // Reset during SORT cycle 3 discards the burst
    load4(4'd5, 4'd1, 4'd3, 4'd2);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    push4(4'd1, 4'd2, 4'd4, 4'd6);
    load4(4'd6, 4'd2, 4'd4, 4'd1);
    run_sort(4'd6, 4'd2, 0, 1'b0);
    drain4(8'hff, 1'b0);

    // Non-one-hot comparator in SORT cycle 2; data swaps on every compare anyway
    push4(4'd1, 4'd2, 4'd3, 4'd4);
    load4(4'd4, 4'd3, 4'd2, 4'd1);
    run_sort(4'd4, 4'd3, 2, 1'b1);
    drain4(8'hff, 1'b0);
    check("cmp_err_sticky_idle", int'(cmp_err), 1);
    push4(4'd2, 4'd5, 4'd5, 4'd9);
    load4(4'd5, 4'd9, 4'd2, 4'd5);
    run_sort(4'd5, 4'd9, 0, 1'b1);
    drain4(8'hff, 1'b0);
    check("cmp_err_sticky_next", int'(cmp_err), 1);
    do_reset();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
